// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle between the ID/EX register, the write-back forwarding
// path and the EX stage.
//   master : the ID/EX + WB side. Drives decoded controls, operands, register
//            numbers, the multiply/flush requests and the WB forwarding data.
//            Receives the EX/MEM register contents, BranchTakenE and MulBusy.
//   slave  : the EX stage (ex_stage). Port directions are the reverse of master.
interface ex_stage_if;
  // ID/EX controls and data
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        RegDstE;
  logic        BeqE;
  logic [2:0]  ALUCtrlE;
  logic [31:0] RData1E;
  logic [31:0] RData2E;
  logic [31:0] Imm32E;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  RdE;
  logic        MultE;
  logic [1:0]  HiLoSelE;
  logic        FlushE;
  // write-back forwarding source
  logic [31:0] ResultW;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  // EX/MEM register and status
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        BranchTakenE;
  logic        MulBusy;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BeqE, ALUCtrlE,
           RData1E, RData2E, Imm32E, RsE, RtE, RdE, MultE, HiLoSelE, FlushE,
           ResultW, RegWriteW, WriteRegW,
    input  RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
           BranchTakenE, MulBusy
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BeqE, ALUCtrlE,
           RData1E, RData2E, Imm32E, RsE, RtE, RdE, MultE, HiLoSelE, FlushE,
           ResultW, RegWriteW, WriteRegW,
    output RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
           BranchTakenE, MulBusy
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline.
// Forwards operands from MEM/WB, runs the ALU and the branch compare, and
// iterates a 32-cycle shift-add unsigned multiplier into HI/LO. All results
// are registered into the EX/MEM pipeline register (1-cycle latency).
// Ports:
//   Clk   : clock, all state changes on posedge
//   Reset : synchronous active-high reset (EX/MEM, HI/LO, multiplier)
//   bus   : ex_stage_if.slave (ID/EX inputs, WB forwarding, EX/MEM outputs,
//           combinational BranchTakenE, registered MulBusy)
module ex_stage #(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  ex_stage_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  // EX/MEM register
  logic        regwrite_m_q;
  logic        memtoreg_m_q;
  logic        memwrite_m_q;
  logic [31:0] aluout_m_q;
  logic [31:0] wdata_m_q;
  logic [4:0]  wreg_m_q;

  // multiplier state
  mul_state_e  mul_state_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // combinational datapath
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_s;
  logic [31:0] result_d;
  logic [4:0]  wreg_d;
  logic [63:0] acc_sum_s;

  // Operand A forwarding: MEM result wins over WB; register 0 never forwards
  always_comb begin
    a_s = bus.RData1E;
    if (regwrite_m_q && (wreg_m_q != 5'd0) && (wreg_m_q == bus.RsE)) begin
      a_s = aluout_m_q;
    end else if (bus.RegWriteW && (bus.WriteRegW != 5'd0) && (bus.WriteRegW == bus.RsE)) begin
      a_s = bus.ResultW;
    end else begin
      a_s = bus.RData1E;
    end
  end

  // Operand B forwarding: same priority rule on Rt
  always_comb begin
    b_s = bus.RData2E;
    if (regwrite_m_q && (wreg_m_q != 5'd0) && (wreg_m_q == bus.RtE)) begin
      b_s = aluout_m_q;
    end else if (bus.RegWriteW && (bus.WriteRegW != 5'd0) && (bus.WriteRegW == bus.RtE)) begin
      b_s = bus.ResultW;
    end else begin
      b_s = bus.RData2E;
    end
  end

  // ALU: second operand mux then the operation
  always_comb begin
    alu_b_s = bus.ALUSrcE ? bus.Imm32E : b_s;
    alu_s   = 32'd0;
    case (bus.ALUCtrlE)
      3'b000:  alu_s = a_s + alu_b_s;
      3'b001:  alu_s = a_s - alu_b_s;
      3'b010:  alu_s = a_s & alu_b_s;
      3'b011:  alu_s = a_s | alu_b_s;
      3'b100:  alu_s = ($signed(a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
      3'b101:  alu_s = {bus.Imm32E[15:0], 16'd0};
      default: alu_s = 32'd0;
    endcase
  end

  // Result select: HI/LO reads return the last committed product only
  always_comb begin
    result_d = alu_s;
    case (bus.HiLoSelE)
      2'b01:   result_d = lo_q;
      2'b10:   result_d = hi_q;
      default: result_d = alu_s;
    endcase
    wreg_d = bus.RegDstE ? bus.RdE : bus.RtE;
  end

  // One shift-add step: accumulate the shifted multiplicand when the low multiplier bit is set
  always_comb begin
    acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  end

  // EX/MEM pipeline register; a flush kills the controls but data still latches
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      aluout_m_q   <= 32'd0;
      wdata_m_q    <= 32'd0;
      wreg_m_q     <= 5'd0;
    end else begin
      regwrite_m_q <= bus.RegWriteE & ~bus.FlushE;
      memtoreg_m_q <= bus.MemtoRegE & ~bus.FlushE;
      memwrite_m_q <= bus.MemWriteE & ~bus.FlushE;
      aluout_m_q   <= result_d;
      wdata_m_q    <= b_s;
      wreg_m_q     <= wreg_d;
    end
  end

  // Multiplier FSM: IDLE captures operands, RUN iterates MULT_CYCLES times then commits HI/LO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mul_state_q <= MUL_IDLE;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      mcand_q     <= 64'd0;
      mplier_q    <= 32'd0;
      acc_q       <= 64'd0;
      cnt_q       <= '0;
    end else begin
      case (mul_state_q)
        MUL_IDLE: begin
          if (bus.MultE && !bus.FlushE) begin
            mcand_q     <= {32'd0, a_s};
            mplier_q    <= b_s;
            acc_q       <= 64'd0;
            cnt_q       <= '0;
            mul_state_q <= MUL_RUN;
            busy_q      <= 1'b1;
          end else begin
            busy_q      <= 1'b0;
          end
        end
        MUL_RUN: begin
          // MultE and FlushE are ignored here; the hazard unit stalls on MulBusy
          acc_q    <= acc_sum_s;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            hi_q        <= acc_sum_s[63:32];
            lo_q        <= acc_sum_s[31:0];
            mul_state_q <= MUL_IDLE;
            busy_q      <= 1'b0;
          end else begin
            busy_q      <= 1'b1;
          end
        end
        default: begin
          mul_state_q <= MUL_IDLE;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RegWriteM    = regwrite_m_q;
  assign bus.MemtoRegM    = memtoreg_m_q;
  assign bus.MemWriteM    = memwrite_m_q;
  assign bus.ALUOutM      = aluout_m_q;
  assign bus.WriteDataM   = wdata_m_q;
  assign bus.WriteRegM    = wreg_m_q;
  assign bus.BranchTakenE = bus.BeqE & (a_s == b_s);
  assign bus.MulBusy      = busy_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Consumer end of the ID/EX pipeline interface: takes the ID/EX register outputs and executes the instruction.
- Contains the forwarding muxes, the ALU, the branch compare, and an iterative 32-cycle unsigned multiplier with HI/LO registers.
- Registers all results into the EX/MEM pipeline register.
- Sits between the ID/EX register and the MEM stage; reports multiplier busy status to the hazard unit.

Parameters:
- MULT_CYCLES, 32, number of iteration cycles of the shift-add multiplier (fixed 32 for 32-bit operands).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BeqE  in  1 each  control bits from ID/EX.
- ALUCtrlE  in  3  ALU operation.
- RData1E, RData2E  in  32  register-file read data from ID/EX.
- Imm32E  in  32  zero-extended immediate.
- RsE, RtE, RdE  in  5 each  register numbers.
- MultE  in  1  start an unsigned multiply of A x B.
- HiLoSelE  in  2  result select: 00 = ALU, 01 = LO, 10 = HI, 11 = ALU.
- FlushE  in  1  convert the current EX instruction into a bubble.
- ResultW  in  32  write-back data, for forwarding.
- RegWriteW  in  1  write-back stage writes a register.
- WriteRegW  in  5  write-back stage destination register.
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  EX/MEM control outputs.
- ALUOutM  out  32  registered result.
- WriteDataM  out  32  registered store data (forwarded B, before the ALUSrc mux).
- WriteRegM  out  5  registered destination register.
- BranchTakenE  out  1  combinational: BeqE & (A == B).
- MulBusy  out  1  multiplier running.

Behaviour:
- Forwarding for A (Rs), combinational:
  - If RegWriteM, WriteRegM != 0 and WriteRegM == RsE: A = ALUOutM.
  - Else if RegWriteW, WriteRegW != 0 and WriteRegW == RsE: A = ResultW.
  - Else A = RData1E.
  - MEM has priority over WB.
- Forwarding for B (Rt): identical rule using RtE and RData2E.
- ALU second operand = ALUSrcE ? Imm32E : B.
- ALUCtrl encoding (result 32 bits, overflow ignored):
  - 000 = add, 001 = sub, 010 = and, 011 = or, 100 = slt (signed, result 1 or 0), 101 = lui (Imm32E << 16).
  - 110 and 111 produce 0.
- Destination: WriteRegE = RegDstE ? RdE : RtE.
- EX/MEM register, on each posedge:
  - Latches RegWrite, MemtoReg, MemWrite, the selected result, B and WriteRegE.
  - Latency is 1 cycle.
- FlushE = 1 at an edge: RegWriteM, MemtoRegM and MemWriteM load 0; the data fields still latch their inputs.
- Reset = 1 at an edge: all EX/MEM outputs, HI, LO and MulBusy go to 0; the multiplier goes to IDLE.
- Multiplier states: IDLE, RUN.
  - IDLE with MultE = 1 and FlushE = 0 at an edge: capture A and B, clear the 64-bit accumulator, counter = 0, go to RUN; MulBusy = 1 from the next cycle.
  - RUN: each edge, if the multiplier bit is 1 add the shifted multiplicand; counter increments.
  - At the edge where the counter reaches MULT_CYCLES-1: write {HI, LO} = product, go to IDLE, MulBusy = 0 after that edge.
  - Net result: MultE sampled at edge t gives HI/LO valid after edge t+32, with MulBusy high for 32 cycles.
- MultE while in RUN: ignored (the hazard unit stalls on MulBusy).
- FlushE while in RUN: no effect on the running multiply.
- Reset while in RUN: aborts; HI and LO = 0.
- HiLoSelE 01/10 reads the committed HI/LO (not a running partial); this read is not forwarded across an in-flight multiply.
- The multiply instruction itself passes through EX/MEM with whatever control it carries (normally RegWrite = 0).

Test Plan:
- Reset: assert Reset for 2 cycles -> all outputs 0, MulBusy = 0.
- ALU path: A = 5, B = 7, sub, RegDstE = 1, RdE = 9 -> next cycle ALUOutM = 0xFFFFFFFE, WriteRegM = 9. Repeat with slt -> ALUOutM = 1. Repeat with lui, Imm32E = 0x1234 -> ALUOutM = 0x12340000.
- Forwarding priority: RsE = 3, WriteRegM = 3 (RegWriteM = 1, ALUOutM = 0x10), WriteRegW = 3 (ResultW = 0x20) -> A = 0x10. With WriteRegM = 0 -> A = 0x20. RsE = 0 -> A = RData1E.
- Branch: BeqE = 1 with forwarded equal operands -> BranchTakenE = 1 in the same cycle; unequal -> 0.
- Multiply: MultE with A = 0xFFFFFFFF, B = 2 -> MulBusy high for exactly 32 cycles, then HI = 1, LO = 0xFFFFFFFE. HiLoSelE = 10 -> ALUOutM = 1.
- Flush and reset mid-operation: FlushE with RegWriteE = 1 -> RegWriteM = 0. Reset at cycle 10 of a multiply -> MulBusy = 0, HI = LO = 0. A new MultE then completes normally.
